// File: rtl/uart_gain_loader_pkg.sv
// Shared types and constants for the UART gain loader: frame constants, gain map, parser/error codes.
package uart_gain_pkg;

   localparam int unsigned GAIN_W    = 16;
   localparam int unsigned NUM_GAINS = 6;
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      GA_P_TACH = 3'd0,
      GA_I_TACH = 3'd1,
      GA_D_TACH = 3'd2,
      GA_P_WALL = 3'd3,
      GA_I_WALL = 3'd4,
      GA_D_WALL = 3'd5
   } gain_addr_e;

   typedef enum logic [2:0] {
      PS_IDLE    = 3'd0,
      PS_ADDR    = 3'd1,
      PS_DATA_HI = 3'd2,
      PS_DATA_LO = 3'd3,
      PS_CHK     = 3'd4
   } parser_state_e;

   typedef enum logic [1:0] {
      ERR_FRAMING  = 2'd0,
      ERR_BAD_ADDR = 2'd1,
      ERR_CHECKSUM = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_code_e;

   // Payload of one gain write once a frame has been accepted.
   typedef struct packed {
      logic [2:0]        addr;
      logic [GAIN_W-1:0] data;
   } gain_wr_t;

   function automatic logic [7:0] frame_chk(input logic [7:0] addr_b,
                                            input logic [7:0] hi_b,
                                            input logic [7:0] lo_b);
      return addr_b ^ hi_b ^ lo_b;
   endfunction

endpackage

// File: rtl/uart_gain_loader_rx.sv
// 8N1 UART byte receiver with input synchroniser, mid-bit sampling and framing-error detection.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 1085
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_serial,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_frame_err
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } rx_state_e;

   rx_state_e        state;
   logic [1:0]       sync_q;
   logic             rx_s;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   assign rx_s = sync_q[1];

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], rx_serial};
   end

   // Idle is only entered with the line high, so a low level in idle is a falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= RX_IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         shift        <= '0;
         rx_valid     <= 1'b0;
         rx_byte      <= '0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         case (state)
            RX_IDLE: begin
               cnt <= '0;
               if (!rx_s) state <= RX_START;
            end
            RX_START: begin
               if (cnt == HALF_M1) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (cnt == FULL_M1) begin
                  cnt   <= '0;
                  shift <= {rx_s, shift[7:1]};
                  if (bit_idx == 3'd7) state <= RX_STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (cnt == FULL_M1) begin
                  cnt <= '0;
                  if (rx_s) begin
                     rx_valid <= 1'b1;
                     rx_byte  <= shift;
                     state    <= RX_IDLE;
                  end else begin
                     rx_frame_err <= 1'b1;
                     state        <= RX_WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_WAIT_HIGH: begin
               if (rx_s) state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_gain_loader.sv
// UART command receiver: frames 5-byte gain writes, checks them, and holds the six PID gains.
module uart_gain_loader
   import uart_gain_pkg::*;
#(
   parameter int unsigned   CLKS_PER_BIT = 1085,
   parameter int unsigned   TIMEOUT_BITS = 20,
   parameter logic [15:0]   K_P_TACH_RST = 16'h0F00,
   parameter logic [15:0]   K_P_WALL_RST = 16'h0040
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_serial,
   input  logic              load_en,
   output logic [GAIN_W-1:0] k_p_tach,
   output logic [GAIN_W-1:0] k_i_tach,
   output logic [GAIN_W-1:0] k_d_tach,
   output logic [GAIN_W-1:0] k_p_wall,
   output logic [GAIN_W-1:0] k_i_wall,
   output logic [GAIN_W-1:0] k_d_wall,
   output logic              gain_update,
   output logic [2:0]        gain_addr,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TMO_W      = $clog2(TMO_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

   logic              rx_valid;
   logic [7:0]        rx_byte;
   logic              rx_frame_err;

   parser_state_e     ps;
   logic [7:0]        addr_q;
   logic [7:0]        hi_q;
   logic [7:0]        lo_q;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [GAIN_W-1:0] gain_q [NUM_GAINS];
   gain_wr_t          wr_c;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk          (clk),
      .reset        (reset),
      .rx_serial    (rx_serial),
      .rx_valid     (rx_valid),
      .rx_byte      (rx_byte),
      .rx_frame_err (rx_frame_err)
   );

   assign wr_c.addr = addr_q[2:0];
   assign wr_c.data = {hi_q, lo_q};

   function automatic logic [GAIN_W-1:0] gain_reset_val(input int unsigned idx);
      if (3'(idx) == GA_P_TACH) return K_P_TACH_RST;
      if (3'(idx) == GA_P_WALL) return K_P_WALL_RST;
      return '0;
   endfunction

   // Parser, timeout and gain registers; a completed byte takes priority over timeout expiry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ps          <= PS_IDLE;
         addr_q      <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         tmo_cnt     <= '0;
         gain_update <= 1'b0;
         gain_addr   <= '0;
         err         <= 1'b0;
         err_code    <= ERR_FRAMING;
         for (int unsigned i = 0; i < NUM_GAINS; i++) gain_q[i] <= gain_reset_val(i);
      end else begin
         gain_update <= 1'b0;
         err         <= 1'b0;
         if (rx_frame_err) begin
            err      <= 1'b1;
            err_code <= ERR_FRAMING;
            ps       <= PS_IDLE;
            tmo_cnt  <= '0;
         end else if (rx_valid) begin
            tmo_cnt <= '0;
            case (ps)
               PS_IDLE:    if (rx_byte == SYNC_BYTE) ps <= PS_ADDR;
               PS_ADDR:    begin addr_q <= rx_byte; ps <= PS_DATA_HI; end
               PS_DATA_HI: begin hi_q   <= rx_byte; ps <= PS_DATA_LO; end
               PS_DATA_LO: begin lo_q   <= rx_byte; ps <= PS_CHK;     end
               PS_CHK: begin
                  ps <= PS_IDLE;
                  if (rx_byte != frame_chk(addr_q, hi_q, lo_q)) begin
                     err      <= 1'b1;
                     err_code <= ERR_CHECKSUM;
                  end else if (addr_q > 8'd5) begin
                     err      <= 1'b1;
                     err_code <= ERR_BAD_ADDR;
                  end else if (load_en) begin
                     gain_update <= 1'b1;
                     gain_addr   <= wr_c.addr;
                     for (int unsigned i = 0; i < NUM_GAINS; i++)
                        if (wr_c.addr == 3'(i)) gain_q[i] <= wr_c.data;
                  end
               end
               default: ps <= PS_IDLE;
            endcase
         end else if (ps != PS_IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
               err      <= 1'b1;
               err_code <= ERR_TIMEOUT;
               ps       <= PS_IDLE;
               tmo_cnt  <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

   assign k_p_tach = gain_q[0];
   assign k_i_tach = gain_q[1];
   assign k_d_tach = gain_q[2];
   assign k_p_wall = gain_q[3];
   assign k_i_wall = gain_q[4];
   assign k_d_wall = gain_q[5];

endmodule

// File: doc/uart_gain_loader.md
# uart_gain_loader

Serial command receiver that loads the six PID gains (tachometer and wall-follower P/I/D, Q8.8 unsigned) over UART. It is the receive-direction counterpart of the telemetry UART transmitter. It shares the 115200-baud 8N1 link settings with that transmitter and replaces push-button gain tuning in `top`. It deserialises bytes, frames and checks fixed 5-byte commands, and commits valid writes to registered gain outputs that drive the PID controllers directly.

## Interface
- `CLKS_PER_BIT`, 1085, clock cycles per UART bit (125 MHz / 115200).
- `TIMEOUT_BITS`, 20, inter-byte timeout expressed in bit periods.
- `K_P_TACH_RST`, 16'h0F00, reset value of `k_p_tach`. All other gains reset to 16'h0000, except `K_P_WALL_RST`, 16'h0040.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `rx_serial` in 1: UART line, idle high, asynchronous to `clk`.
- `load_en` in 1: commit enable. Frames are parsed regardless, but committed only when high.
- `k_p_tach`, `k_i_tach`, `k_d_tach` out 16 each: tachometer gains, Q8.8.
- `k_p_wall`, `k_i_wall`, `k_d_wall` out 16 each: wall-follower gains, Q8.8.
- `gain_update` out 1: one-cycle pulse on commit.
- `gain_addr` out 3: address of the last committed gain.
- `err` out 1: one-cycle pulse on a rejected frame.
- `err_code` out 2: 0 framing, 1 bad address, 2 checksum, 3 timeout. Holds until the next `err` pulse.

## Operation
- Frame format: `0xA5`, ADDR, DATA_HI, DATA_LO, CHK, where CHK = ADDR ^ DATA_HI ^ DATA_LO.
- ADDR map: 0 k_p_tach, 1 k_i_tach, 2 k_d_tach, 3 k_p_wall, 4 k_i_wall, 5 k_d_wall. Addresses 6 and 7 are invalid.
- **UART receiver**
  - `rx_serial` passes through a 2-FF synchroniser.
  - A falling edge while idle starts the bit counter.
  - The start bit is re-sampled at CLKS_PER_BIT/2. If it is high, this is a false start: return to idle with no error.
  - Data bits are sampled every CLKS_PER_BIT, LSB first. The stop bit is sampled once.
  - Stop bit high: pulse `rx_valid` with `rx_byte`.
  - Stop bit low: pulse framing error, discard the byte, and wait for the line to go high before re-arming.
- **Parser states:** IDLE, ADDR, DATA_HI, DATA_LO, CHK.
  - IDLE: `0xA5` moves to ADDR. Any other byte is discarded silently.
  - ADDR: latch the byte and go to DATA_HI. Address validity is checked only at CHK, so the frame length is always 5.
  - DATA_HI → DATA_LO → CHK, each advancing on `rx_valid`.
  - `0xA5` in any non-IDLE position is data; it does not resync.
  - CHK, checksum mismatch: err code 2.
  - CHK, checksum OK but ADDR > 5: err code 1.
  - CHK, otherwise: commit if `load_en`. If `load_en` is low, drop silently.
  - CHK always returns to IDLE.
- **Framing error in any state:** `err` with code 0, parser to IDLE.
- **Timeout:**
  - The counter runs only while the parser is not in IDLE and resets on every `rx_valid`.
  - Expiry at TIMEOUT_BITS*CLKS_PER_BIT cycles gives `err` with code 3 and returns the parser to IDLE.
  - A byte completing in the same cycle as expiry wins: no timeout.
- **Commit:** gain[ADDR] <= {DATA_HI, DATA_LO}, `gain_addr` <= ADDR, `gain_update` pulses. All other gains are unchanged.

## Timing
- Reset values:
  - Gains at their reset values.
  - `gain_update` 0, `err` 0, `err_code` 0, `gain_addr` 0.
  - Parser IDLE, receiver idle.
- Reset mid-frame aborts the frame; no partial write is ever visible.
- `rx_valid` occurs 2 + 9.5*CLKS_PER_BIT (±1) cycles after the start-bit falling edge on `rx_serial`.
- Commit latency: the gain output, `gain_addr` and `gain_update` all change in the cycle after the CHK byte's `rx_valid`.
- `err` also asserts in the cycle after the triggering event. `err_code` updates in the same cycle.
- Gains change only on commit, so they are stable between updates. A consumer may sample them on its own clock enable without a handshake.
- Back-to-back frames with zero idle gap are supported. The receiver re-arms on the stop-bit sample.

## Structure
- Package `uart_gain_pkg` contains:
  - `SYNC_BYTE` = 8'hA5
  - `gain_addr_e` enum with values 0–5
  - `parser_state_e`
  - `err_code_e`
  - `GAIN_W` = 16
- Sub-module `uart_rx` (parameter `CLKS_PER_BIT`): ports `clk`, `reset`, `rx_serial`, `rx_valid`, `rx_byte`, `rx_frame_err`. The synchroniser lives inside it.
- The top level holds the parser FSM, the timeout counter and six gain registers.

## Test plan
All directed tests run with CLKS_PER_BIT=16.
- **Reset check:** after reset, `k_p_tach`=0x0F00, `k_p_wall`=0x0040, all other gains 0, no pulses.
- **Valid write:** `load_en`=1, send A5 01 02 80 83. Expect `k_i_tach`=0x0280, one `gain_update`, `gain_addr`=1, all other gains unchanged.
- **Noise then frame:** send 00 FF 33, then A5 05 12 34 23. Expect `k_d_wall`=0x1234 with no `err`.
- **Bad checksum and bad address:**
  - Send A5 00 01 00 00. Expect `err` with code 2, no write.
  - Send A5 06 00 00 06. Expect `err` with code 1, no write.
- **Timeout and framing:**
  - Send A5 03 and idle 21 bit-times. Expect `err` with code 3 and the parser back in IDLE. A following valid frame then commits.
  - Force the stop bit low mid-frame. Expect code 0 and no write.
- **Enable gate and mid-frame reset:**
  - Send a valid frame with `load_en`=0. Expect no change and no pulses.
  - Assert reset during DATA_LO. Expect the reset values, and the remaining bytes are ignored until the next `0xA5`.
